// File: rtl/pmod_ssd_if.sv
// Pin-level bundle for the PmodSSD display: segment/select lines plus the recovered digit state.
// slave is the capture block; master is whoever drives the pins and observes the results.
interface pmod_ssd_if;
    logic       SSD_AA;
    logic       SSD_AB;
    logic       SSD_AC;
    logic       SSD_AD;
    logic       SSD_AE;
    logic       SSD_AF;
    logic       SSD_AG;
    logic       SSD_C;
    logic [4:0] digit0;
    logic [4:0] digit1;
    logic       illegal0;
    logic       illegal1;
    logic       frame_valid;
    logic       stalled;

    modport slave (
        input  SSD_AA, SSD_AB, SSD_AC, SSD_AD, SSD_AE, SSD_AF, SSD_AG, SSD_C,
        output digit0, digit1, illegal0, illegal1, frame_valid, stalled
    );

    modport master (
        output SSD_AA, SSD_AB, SSD_AC, SSD_AD, SSD_AE, SSD_AF, SSD_AG, SSD_C,
        input  digit0, digit1, illegal0, illegal1, frame_valid, stalled
    );
endinterface

// File: rtl/pmod_ssd_capture.sv
// Receive side of the PmodSSD link: recovers the two multiplexed digit codes from the segment
// and digit-select pins, flags undecodable patterns and a stalled multiplex clock.
module pmod_ssd_capture #(
    parameter int unsigned SIMULATE        = 1,
    parameter int unsigned SEG_ACTIVE_HIGH = 1,
    parameter int unsigned SETTLE_CYCLES   = 4,
    parameter int unsigned STABLE_COUNT    = 8,
    parameter int unsigned TIMEOUT_CYCLES  = 2000000,
    parameter int unsigned TIMEOUT_SIM     = 64
) (
    input  logic      clk,
    input  logic      reset,
    pmod_ssd_if.slave ssd
);
    localparam int unsigned Timeout = (SIMULATE != 0) ? TIMEOUT_SIM : TIMEOUT_CYCLES;
    localparam int unsigned WdW     = $clog2(Timeout + 1);
    localparam logic [WdW-1:0] TimeoutW = WdW'(Timeout);

    typedef enum logic [1:0] {StIdle, StSettle, StSample, StHold} state_e;

    logic [7:0]     pins;
    logic [7:0]     sync1_q, sync2_q;
    logic           c_prev_q;
    logic           c_sync, c_edge;
    logic [6:0]     seg;
    state_e         state_q, state_d;
    logic           phase_q, phase_d;
    logic [7:0]     settle_q, settle_d;
    logic [7:0]     match_q, match_d;
    logic [6:0]     ref_q, ref_d;
    logic [4:0]     digit0_q, digit0_d, digit1_q, digit1_d;
    logic           illegal0_q, illegal0_d, illegal1_q, illegal1_d;
    logic           cap0_q, cap0_d, cap1_q, cap1_d;
    logic           frame_q, frame_d;
    logic [WdW-1:0] wdog_q, wdog_d;
    logic           stalled_q, stalled_d;
    logic           cap_en;
    logic [4:0]     code;

    assign pins = {ssd.SSD_C, ssd.SSD_AG, ssd.SSD_AF, ssd.SSD_AE,
                   ssd.SSD_AD, ssd.SSD_AC, ssd.SSD_AB, ssd.SSD_AA};

    assign c_sync = sync2_q[7];
    assign c_edge = c_sync ^ c_prev_q;
    assign seg    = (SEG_ACTIVE_HIGH != 0) ? sync2_q[6:0] : ~sync2_q[6:0];

    // gfedcba pattern to code; 5'h1F marks an undecodable pattern.
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'h3F:   decode = 5'h00;
            7'h06:   decode = 5'h01;
            7'h5B:   decode = 5'h02;
            7'h4F:   decode = 5'h03;
            7'h66:   decode = 5'h04;
            7'h6D:   decode = 5'h05;
            7'h7D:   decode = 5'h06;
            7'h07:   decode = 5'h07;
            7'h7F:   decode = 5'h08;
            7'h6F:   decode = 5'h09;
            7'h77:   decode = 5'h0A;
            7'h7C:   decode = 5'h0B;
            7'h39:   decode = 5'h0C;
            7'h5E:   decode = 5'h0D;
            7'h79:   decode = 5'h0E;
            7'h71:   decode = 5'h0F;
            7'h00:   decode = 5'h10;
            default: decode = 5'h1F;
        endcase
    endfunction

    assign code = decode(ref_q);

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        settle_d   = settle_q;
        match_d    = match_q;
        ref_d      = ref_q;
        digit0_d   = digit0_q;
        digit1_d   = digit1_q;
        illegal0_d = illegal0_q;
        illegal1_d = illegal1_q;
        cap_en     = 1'b0;

        frame_d = cap0_q & cap1_q;
        cap0_d  = cap0_q & ~frame_d;
        cap1_d  = cap1_q & ~frame_d;

        wdog_d    = c_edge ? '0 : ((wdog_q == TimeoutW) ? wdog_q : wdog_q + 1'b1);
        stalled_d = (wdog_d == TimeoutW);

        // An edge abandons whatever phase is in progress, even on the capture cycle.
        if (c_edge) begin
            state_d  = StSettle;
            phase_d  = c_sync;
            settle_d = 8'(SETTLE_CYCLES - 1);
        end else begin
            case (state_q)
                StSettle: begin
                    if (settle_q == 8'd0) begin
                        state_d = StSample;
                        ref_d   = seg;
                        match_d = 8'd1;
                    end else begin
                        settle_d = settle_q - 8'd1;
                    end
                end
                StSample: begin
                    if (match_q == 8'(STABLE_COUNT)) begin
                        cap_en  = 1'b1;
                        state_d = StHold;
                    end else if (seg == ref_q) begin
                        match_d = match_q + 8'd1;
                    end else begin
                        ref_d   = seg;
                        match_d = 8'd1;
                    end
                end
                default: ;
            endcase
        end

        if (cap_en) begin
            if (phase_q) begin
                digit0_d   = code;
                illegal0_d = (code == 5'h1F);
                cap0_d     = 1'b1;
            end else begin
                digit1_d   = code;
                illegal1_d = (code == 5'h1F);
                cap1_d     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            c_prev_q   <= 1'b0;
            state_q    <= StIdle;
            phase_q    <= 1'b0;
            settle_q   <= '0;
            match_q    <= '0;
            ref_q      <= '0;
            digit0_q   <= '0;
            digit1_q   <= '0;
            illegal0_q <= 1'b0;
            illegal1_q <= 1'b0;
            cap0_q     <= 1'b0;
            cap1_q     <= 1'b0;
            frame_q    <= 1'b0;
            wdog_q     <= '0;
            stalled_q  <= 1'b0;
        end else begin
            sync1_q    <= pins;
            sync2_q    <= sync1_q;
            c_prev_q   <= c_sync;
            state_q    <= state_d;
            phase_q    <= phase_d;
            settle_q   <= settle_d;
            match_q    <= match_d;
            ref_q      <= ref_d;
            digit0_q   <= digit0_d;
            digit1_q   <= digit1_d;
            illegal0_q <= illegal0_d;
            illegal1_q <= illegal1_d;
            cap0_q     <= cap0_d;
            cap1_q     <= cap1_d;
            frame_q    <= frame_d;
            wdog_q     <= wdog_d;
            stalled_q  <= stalled_d;
        end
    end

    assign ssd.digit0      = digit0_q;
    assign ssd.digit1      = digit1_q;
    assign ssd.illegal0    = illegal0_q;
    assign ssd.illegal1    = illegal1_q;
    assign ssd.frame_valid = frame_q;
    assign ssd.stalled     = stalled_q;
endmodule
